// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx -- asynchronous serial receiver (start + DATA_BITS + [parity] + stop).
//
// Build option: define UART_RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit. Without it parity_err is constant 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sample_tick  one-clk pulse at OVERSAMPLE x baud rate
//   rx           serial line, idle high, asynchronous to clk
//   data_out     received byte, stable while data_valid=1
//   data_valid   byte available
//   data_ready   consumer accepts data_out when high together with data_valid
//   busy         high whenever the receive FSM is not IDLE
//   frame_err    one-clk pulse: stop bit sampled low
//   overrun_err  one-clk pulse: frame completed while previous byte unaccepted
//   parity_err   one-clk pulse: parity mismatch
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK_WAIT
  } state_t;

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;
  logic [TW-1:0]          tick_cnt_reg, tick_next;
  logic [BW-1:0]          bit_cnt_reg, bit_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [DATA_BITS-1:0]   data_out_reg;
  logic                   data_valid_reg, frame_err_reg, overrun_err_reg, parity_err_reg;
  logic                   deliver, frame_fail, parity_fail;
`ifdef UART_RX_PARITY_EN
  logic                   parity_reg, parity_next;
`endif

  // Input synchronizer; presets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_reg <= '1;
    else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
`ifdef UART_RX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_next;
      bit_cnt_reg  <= bit_next;
      shift_reg    <= shift_next;
`ifdef UART_RX_PARITY_EN
      parity_reg   <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    tick_next   = tick_cnt_reg;
    bit_next    = bit_cnt_reg;
    shift_next  = shift_reg;
    deliver     = 1'b0;
    frame_fail  = 1'b0;
    parity_fail = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_next = parity_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (sample_tick && !rx_s) begin
          state_next = START;
          tick_next  = '0;
        end
      end
      START: begin
        if (sample_tick) begin
          if (tick_cnt_reg == HALF_TICK) begin
            // Re-check mid start bit: a high line here was only a glitch.
            if (!rx_s) begin
              state_next = DATA;
              tick_next  = '0;
              bit_next   = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            tick_next = tick_cnt_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (tick_cnt_reg == FULL_TICK) begin
            // LSB arrives first, so each new bit enters at the top and walks down.
            shift_next = {rx_s, shift_reg[DATA_BITS-1:1]};
            tick_next  = '0;
            bit_next   = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end else begin
            tick_next = tick_cnt_reg + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample_tick) begin
          if (tick_cnt_reg == FULL_TICK) begin
            parity_next = rx_s;
            tick_next   = '0;
            state_next  = STOP;
          end else begin
            tick_next = tick_cnt_reg + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (sample_tick) begin
          if (tick_cnt_reg == FULL_TICK) begin
            tick_next = '0;
            if (rx_s) begin
              state_next = IDLE;
`ifdef UART_RX_PARITY_EN
              if ((^shift_reg) != parity_reg) parity_fail = 1'b1;
              else                            deliver     = 1'b1;
`else
              deliver = 1'b1;
`endif
            end else begin
              // Framing error wins over any parity result.
              frame_fail = 1'b1;
              state_next = BRK_WAIT;
            end
          end else begin
            tick_next = tick_cnt_reg + 1'b1;
          end
        end
      end
      BRK_WAIT: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output holding register and handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_reg    <= '0;
      data_valid_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
      overrun_err_reg <= 1'b0;
      parity_err_reg  <= 1'b0;
    end else begin
      frame_err_reg   <= frame_fail;
      parity_err_reg  <= parity_fail;
      overrun_err_reg <= 1'b0;
      if (deliver) begin
        // A byte accepted this very cycle frees the slot for the new one.
        if (!data_valid_reg || data_ready) begin
          data_out_reg   <= shift_reg;
          data_valid_reg <= 1'b1;
        end else begin
          overrun_err_reg <= 1'b1;
        end
      end else if (data_valid_reg && data_ready) begin
        data_valid_reg <= 1'b0;
      end
    end
  end

  assign data_out    = data_out_reg;
  assign data_valid  = data_valid_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_err   = frame_err_reg;
  assign overrun_err = overrun_err_reg;
  assign parity_err  = parity_err_reg;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx. Expected bytes are queued when a frame is
// sent and popped by a monitor when the DUT presents a new byte.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, busy, frame_err, overrun_err, parity_err;

  int total = 0;
  int bad   = 0;
  int tick_div = 4;
  int tick_phase = 0;
  int vcnt = 0, fe_cnt = 0, oe_cnt = 0, pe_cnt = 0;
  logic busy_seen = 1'b0;
  logic prev_dv = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .rx(rx),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .busy(busy), .frame_err(frame_err), .overrun_err(overrun_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Tick generator: one pulse every tick_div clocks (tick_div=1 -> continuous).
  initial forever begin
    @(negedge clk);
    if (tick_phase >= tick_div - 1) begin
      sample_tick = 1'b1;
      tick_phase  = 0;
    end else begin
      sample_tick = 1'b0;
      tick_phase++;
    end
  end

  // Monitor: scoreboard pop on every newly presented byte, pulse counting.
  initial forever begin
    logic accepted;
    logic [7:0] exp_b;
    @(posedge clk);
    #1;
    accepted = prev_dv && data_ready;
    if (data_valid && (!prev_dv || accepted)) begin
      vcnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_byte: got=%02h required=none", data_out);
      end else begin
        exp_b = exp_q.pop_front();
        if (data_out !== exp_b) begin
          bad++;
          $display("FAIL byte_value: got=%02h required=%02h", data_out, exp_b);
        end
      end
    end
    if (frame_err)   fe_cnt++;
    if (overrun_err) oe_cnt++;
    if (parity_err)  pe_cnt++;
    if (busy)        busy_seen = 1'b1;
    prev_dv = data_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    vcnt = 0; fe_cnt = 0; oe_cnt = 0; pe_cnt = 0; busy_seen = 1'b0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par_en, input logic par_bit);
    int bclk;
    bclk = 16 * tick_div;
    rx = 1'b0;
    wait_clks(bclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(bclk);
    end
    if (par_en) begin
      rx = par_bit;
      wait_clks(bclk);
    end
    rx = stop_bit;
    wait_clks(bclk);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, PAR, ^b);
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx = ~rx;
      @(negedge clk);
      obs = {data_valid, busy, frame_err, overrun_err, parity_err, data_out};
      total++;
      if (obs !== 13'd0) begin
        bad++;
        $display("FAIL reset_state: got=%04h required=0000", obs);
      end
    end
    rx = 1'b1;
    wait_clks(4);
    rst = 1'b0;
    wait_clks(8);
    total++;
    if ({data_valid, busy} !== 2'b00) begin
      bad++;
      $display("FAIL reset_release: dv,busy got=%b required=00", {data_valid, busy});
    end
  endtask

  task automatic test_basic();
    tick_div = 4;
    data_ready = 1'b1;
    clear_counts();
    exp_q.push_back(8'hA5);
    send_good(8'hA5);
    rx = 1'b1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy_after_stop: got=%b required=0", busy);
    end
    wait_clks(128);
    total++;
    if (vcnt != 1) begin
      bad++;
      $display("FAIL basic_valid_count: got=%0d required=1", vcnt);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL basic_pending: got=%0d required=0", exp_q.size());
    end
    total++;
    if (fe_cnt + oe_cnt + pe_cnt != 0) begin
      bad++;
      $display("FAIL basic_errors: got=%0d required=0", fe_cnt + oe_cnt + pe_cnt);
    end
    total++;
    if (busy_seen !== 1'b1) begin
      bad++;
      $display("FAIL basic_busy_seen: got=%b required=1", busy_seen);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    rx = 1'b0;
    wait_clks(8);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL glitch_busy_high: got=%b required=1", busy);
    end
    wait_clks(8);
    rx = 1'b1;
    wait_clks(32);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL glitch_busy_low: got=%b required=0", busy);
    end
    wait_clks(128);
    total++;
    if (vcnt + fe_cnt + oe_cnt + pe_cnt != 0) begin
      bad++;
      $display("FAIL glitch_outputs: got=%0d required=0", vcnt + fe_cnt + oe_cnt + pe_cnt);
    end
  endtask

  task automatic test_frame_err();
    clear_counts();
    send_frame(8'h3C, 1'b0, PAR, 1'b0);
    wait_clks(40 * 4);
    total++;
    if (fe_cnt != 1) begin
      bad++;
      $display("FAIL frame_err_count: got=%0d required=1", fe_cnt);
    end
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL frame_busy_in_break: got=%b required=1", busy);
    end
    rx = 1'b1;
    wait_clks(32);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL frame_busy_after_break: got=%b required=0", busy);
    end
    total++;
    if (vcnt + oe_cnt + pe_cnt != 0) begin
      bad++;
      $display("FAIL frame_other_outputs: got=%0d required=0", vcnt + oe_cnt + pe_cnt);
    end
  endtask

  task automatic test_overrun();
    clear_counts();
    data_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_good(8'h11);
    rx = 1'b1;
    wait_clks(32);
    send_good(8'h22);
    rx = 1'b1;
    wait_clks(64);
    total++;
    if (oe_cnt != 1) begin
      bad++;
      $display("FAIL overrun_count: got=%0d required=1", oe_cnt);
    end
    total++;
    if ({data_valid, data_out} !== {1'b1, 8'h11}) begin
      bad++;
      $display("FAIL overrun_hold: got=%b/%02h required=1/11", data_valid, data_out);
    end
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    total++;
    if (data_valid !== 1'b0) begin
      bad++;
      $display("FAIL overrun_accept_clear: got=%b required=0", data_valid);
    end
    wait_clks(4);
    total++;
    if (vcnt != 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL overrun_bytes: got vcnt=%0d pending=%0d required 1/0", vcnt, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    tick_div = 1;
    data_ready = 1'b1;
    wait_clks(4);
    clear_counts();
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h0F);
    send_good(8'h5A);
    send_good(8'hC3);
    send_good(8'h0F);
    rx = 1'b1;
    wait_clks(40);
    total++;
    if (vcnt != 3 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_bytes: got vcnt=%0d pending=%0d required 3/0", vcnt, exp_q.size());
    end
    total++;
    if (fe_cnt + oe_cnt + pe_cnt != 0) begin
      bad++;
      $display("FAIL b2b_errors: got=%0d required=0", fe_cnt + oe_cnt + pe_cnt);
    end
    tick_div = 4;
    wait_clks(8);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    data_ready = 1'b1;
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    rx = 1'b1;
    wait_clks(64);
    total++;
    if (pe_cnt != 1 || vcnt != 0 || fe_cnt != 0) begin
      bad++;
      $display("FAIL parity_bad: got pe=%0d v=%0d fe=%0d required 1/0/0", pe_cnt, vcnt, fe_cnt);
    end
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    rx = 1'b1;
    wait_clks(64);
    total++;
    if (pe_cnt != 1 || vcnt != 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL parity_good: got pe=%0d v=%0d pending=%0d required 1/1/0", pe_cnt, vcnt, exp_q.size());
    end
  endtask
`endif

  initial begin
    #2 rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(5);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
